// File: rtl/rv32i_decode_stage.sv
// rv32i_decode_stage: registered RV32I decoder. A combinational decoder feeds an
// output register backed by a one-entry skid register, so the fetch side sees a
// registered in_ready and the stage still sustains one instruction per cycle.
module rv32i_decode_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [3:0]       out_class,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic             out_alt,
  output logic [31:0]      out_imm,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_branch,
  output logic             out_jump,
  output logic             out_alu_src,
  output logic             out_illegal,
  output logic [CNT_W-1:0] decode_count,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        alt;
    logic [31:0] imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        alu_src;
    logic        illegal;
  } bundle_t;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd_field;
  logic [4:0]  rs1_field;
  logic [4:0]  rs2_field;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opcode    = in_instr[6:0];
  assign f3        = in_instr[14:12];
  assign f7        = in_instr[31:25];
  assign rd_field  = in_instr[11:7];
  assign rs1_field = in_instr[19:15];
  assign rs2_field = in_instr[24:20];
  assign imm_i     = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b     = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u     = {in_instr[31:12], 12'b0};
  assign imm_j     = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  bundle_t dec;
  logic    use_rd;
  logic    use_rs1;
  logic    use_rs2;
  logic    legal;

  // Decode the offered word into a full bundle; illegal words collapse to class 15.
  always_comb begin
    dec     = '0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    legal   = 1'b1;
    unique case (opcode)
      OPC_OP: begin
        dec.cls = 4'd0;
        use_rd  = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec.alt = in_instr[30];
        legal   = (f7 == 7'b0) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        dec.cls     = 4'd1;
        use_rd      = 1'b1; use_rs1 = 1'b1;
        dec.alu_src = 1'b1;
        // Shift amounts are unsigned; the upper bits carry funct7 instead.
        dec.imm     = ((f3 == 3'b001) || (f3 == 3'b101)) ? {27'b0, in_instr[24:20]} : imm_i;
        dec.alt     = (f3 == 3'b101) ? in_instr[30] : 1'b0;
        legal       = !(((f3 == 3'b001) && (f7 != 7'b0)) ||
                        ((f3 == 3'b101) && (f7 != 7'b0) && (f7 != F7_ALT)));
      end
      OPC_LOAD: begin
        dec.cls      = 4'd2;
        use_rd       = 1'b1; use_rs1 = 1'b1;
        dec.imm      = imm_i;
        dec.mem_read = 1'b1;
        dec.alu_src  = 1'b1;
        legal        = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      end
      OPC_STORE: begin
        dec.cls       = 4'd3;
        use_rs1       = 1'b1; use_rs2 = 1'b1;
        dec.imm       = imm_s;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        legal         = (f3 <= 3'b010);
      end
      OPC_BRANCH: begin
        dec.cls    = 4'd4;
        use_rs1    = 1'b1; use_rs2 = 1'b1;
        dec.imm    = imm_b;
        dec.branch = 1'b1;
        legal      = (f3 != 3'b010) && (f3 != 3'b011);
      end
      OPC_LUI: begin
        dec.cls     = 4'd5;
        use_rd      = 1'b1;
        dec.imm     = imm_u;
        dec.alu_src = 1'b1;
      end
      OPC_AUIPC: begin
        dec.cls     = 4'd6;
        use_rd      = 1'b1;
        dec.imm     = imm_u;
        dec.alu_src = 1'b1;
      end
      OPC_JAL: begin
        dec.cls     = 4'd7;
        use_rd      = 1'b1;
        dec.imm     = imm_j;
        dec.jump    = 1'b1;
        dec.alu_src = 1'b1;
      end
      OPC_JALR: begin
        dec.cls     = 4'd8;
        use_rd      = 1'b1; use_rs1 = 1'b1;
        dec.imm     = imm_i;
        dec.jump    = 1'b1;
        dec.alu_src = 1'b1;
        legal       = (f3 == 3'b000);
      end
      default: legal = 1'b0;
    endcase
    dec.pc        = in_pc;
    dec.funct3    = f3;
    dec.rd        = use_rd  ? rd_field  : 5'd0;
    dec.rs1       = use_rs1 ? rs1_field : 5'd0;
    dec.rs2       = use_rs2 ? rs2_field : 5'd0;
    dec.reg_write = use_rd && (rd_field != 5'd0);
    if (!legal) begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.funct3  = f3;
      dec.cls     = 4'd15;
      dec.illegal = 1'b1;
    end
  end

  bundle_t out_reg, out_next;
  bundle_t skid_reg, skid_next;
  logic    out_valid_reg, out_valid_next;
  logic    skid_valid_reg, skid_valid_next;
  logic    in_ready_reg;
  logic    accept;
  logic    drain;
  logic [CNT_W-1:0] decode_count_reg;
  logic [CNT_W-1:0] illegal_count_reg;

  assign accept = in_valid && in_ready_reg;
  assign drain  = out_valid_reg && out_ready;

  // Steer accepted words: output register when it is free or draining, else the skid.
  always_comb begin
    out_next        = out_reg;
    out_valid_next  = out_valid_reg;
    skid_next       = skid_reg;
    skid_valid_next = skid_valid_reg;
    if (!out_valid_reg || drain) begin
      if (skid_valid_reg) begin
        // in_ready is low while the skid is full, so no accept can collide here.
        out_next        = skid_reg;
        out_valid_next  = 1'b1;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        out_next       = dec;
        out_valid_next = 1'b1;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (accept) begin
      skid_next       = dec;
      skid_valid_next = 1'b1;
    end
  end

  // Pipeline registers; in_ready is registered from the next skid occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg        <= '0;
      skid_reg       <= '0;
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b1;
    end else begin
      out_reg        <= out_next;
      skid_reg       <= skid_next;
      out_valid_reg  <= out_valid_next;
      skid_valid_reg <= skid_valid_next;
      in_ready_reg   <= !skid_valid_next;
    end
  end

  // Saturating delivery counters, stepped on each completed output handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      decode_count_reg  <= '0;
      illegal_count_reg <= '0;
    end else if (drain) begin
      if (decode_count_reg != '1) decode_count_reg <= decode_count_reg + 1'b1;
      if (out_reg.illegal && (illegal_count_reg != '1)) illegal_count_reg <= illegal_count_reg + 1'b1;
    end
  end

  assign in_ready      = in_ready_reg;
  assign out_valid     = out_valid_reg;
  assign out_pc        = out_reg.pc;
  assign out_class     = out_reg.cls;
  assign out_rd        = out_reg.rd;
  assign out_rs1       = out_reg.rs1;
  assign out_rs2       = out_reg.rs2;
  assign out_funct3    = out_reg.funct3;
  assign out_alt       = out_reg.alt;
  assign out_imm       = out_reg.imm;
  assign out_reg_write = out_reg.reg_write;
  assign out_mem_read  = out_reg.mem_read;
  assign out_mem_write = out_reg.mem_write;
  assign out_branch    = out_reg.branch;
  assign out_jump      = out_reg.jump;
  assign out_alu_src   = out_reg.alu_src;
  assign out_illegal   = out_reg.illegal;
  assign decode_count  = decode_count_reg;
  assign illegal_count = illegal_count_reg;

endmodule
